// File: rtl/sd_cmd_serializer.sv
// SD-bus CMD line serializer: start/transmit bits, index, argument, CRC7, end bit.
// Build option: SD_CMD_NCC_EN adds NCC_BITS idle '1' clocks after the end bit.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   sd_clk_fall_i         one-cycle SD-clock falling-edge strobe paces every bit
//   cmd_valid_i/ready_o   command request handshake (accept = valid && ready)
//   cmd_index_i/arg_i     command index and argument, sampled on accept
//   busy_o, done_o        frame in flight / one-cycle end-of-frame pulse
//   cmd_o, cmd_oe_o       registered CMD line data and output enable
//   crc_rst_o, crc_bit_o,
//   crc_valid_o,
//   crc_shift_o           drive an external CRC-7 generator
//   crc_bit_i             current MSB of that generator
module sd_cmd_serializer #(
  parameter int CRC_BITS = 7,
  parameter int NCC_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sd_clk_fall_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        crc_rst_o,
  output logic        crc_bit_o,
  output logic        crc_valid_o,
  output logic        crc_shift_o,
  input  logic        crc_bit_i
);

  // Counter must hold the longest countdown of the three phases.
  localparam int M1 = (CRC_BITS > 40) ? CRC_BITS : 40;
  localparam int M2 = (NCC_BITS > M1) ? NCC_BITS : M1;
  localparam int CW = $clog2(M2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_END,
`ifdef SD_CMD_NCC_EN
    S_NCC,
`endif
    S_REL
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [39:0]   r_sr;
  logic [39:0]   w_sr_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic          r_cmd;
  logic          w_cmd_n;
  logic          r_oe;
  logic          w_oe_n;
  logic          r_done;
  logic          w_done_n;
  logic          w_accept;
  logic          w_last;

  assign w_accept    = cmd_valid_i & (r_state == S_IDLE);
  assign w_last      = (r_cnt == '0);
  assign cmd_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE) | w_accept;
  assign done_o      = r_done;
  assign cmd_o       = r_cmd;
  assign cmd_oe_o    = r_oe;
  // CRC register clears on the edge that accepts a new frame.
  assign crc_rst_o   = rst_i | w_accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_cmd   <= 1'b1;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sr    <= w_sr_n;
      r_cnt   <= w_cnt_n;
      r_cmd   <= w_cmd_n;
      r_oe    <= w_oe_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_sr_n      = r_sr;
    w_cnt_n     = r_cnt;
    w_cmd_n     = r_cmd;
    w_oe_n      = r_oe;
    w_done_n    = 1'b0;
    crc_valid_o = 1'b0;
    crc_shift_o = 1'b0;
    crc_bit_o   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A strobe on the accept cycle is ignored.
        if (w_accept) begin
          w_sr_n    = {1'b0, 1'b1, cmd_index_i, cmd_arg_i};
          w_cnt_n   = CW'(39);
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (sd_clk_fall_i) begin
          w_cmd_n     = r_sr[39];
          w_oe_n      = 1'b1;
          w_sr_n      = {r_sr[38:0], 1'b0};
          crc_valid_o = 1'b1;
          crc_bit_o   = r_sr[39];
          if (w_last) begin
            w_cnt_n   = CW'(CRC_BITS - 1);
            w_state_n = S_CRC;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      end
      S_CRC: begin
        // Generator presents its MSB and shifts zero-filled.
        if (sd_clk_fall_i) begin
          w_cmd_n     = crc_bit_i;
          crc_valid_o = 1'b1;
          crc_shift_o = 1'b1;
          if (w_last) begin
            w_state_n = S_END;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      end
      S_END: begin
        if (sd_clk_fall_i) begin
          w_cmd_n = 1'b1;
`ifdef SD_CMD_NCC_EN
          w_cnt_n   = CW'(NCC_BITS - 1);
          w_state_n = S_NCC;
`else
          w_state_n = S_REL;
`endif
        end
      end
`ifdef SD_CMD_NCC_EN
      S_NCC: begin
        if (sd_clk_fall_i) begin
          w_cmd_n = 1'b1;
          w_oe_n  = 1'b1;
          if (w_last) begin
            w_state_n = S_REL;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      end
`endif
      S_REL: begin
        if (sd_clk_fall_i) begin
          w_cmd_n   = 1'b1;
          w_oe_n    = 1'b0;
          w_cnt_n   = '0;
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

endmodule
